// File: rtl/onehot_bin_encoder_pipe.sv
// onehot_bin_encoder_pipe
//   Streaming one-hot -> binary bin-index encoder. It is a 2-stage elastic pipeline
//   with a valid/ready handshake on each side. It flags multi-hot and zero-hot words
//   and keeps a saturating count of each kind that is delivered downstream.
//   S1 registers the raw one-hot vector. S2 registers the encoded index and the flags.
//   S2 drives the outputs directly.
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready is combinational from out_ready)
//   in_onehot           NUM_BINS-wide one-hot bin vector
//   out_valid/out_ready output handshake
//   out_idx             encoded bin index (PRIO_MODE 0: OR-encode, 1: lowest set bit)
//   out_multi/out_zero  word had >1 / no bit set
//   cnt_clear           synchronous clear of both counters, wins over an increment
//   multi_cnt/zero_cnt  saturating counts of delivered multi-hot / zero-hot words
module onehot_bin_encoder_pipe #(
  parameter int unsigned NUM_BINS  = 16,
  parameter int unsigned IDX_W     = $clog2(NUM_BINS),
  parameter int unsigned PRIO_MODE = 0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_BINS-1:0] in_onehot,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IDX_W-1:0]    out_idx,
  output logic                out_multi,
  output logic                out_zero,
  input  logic                cnt_clear,
  output logic [CNT_W-1:0]    multi_cnt,
  output logic [CNT_W-1:0]    zero_cnt
);

  logic                s1_valid_q, s1_valid_d;
  logic [NUM_BINS-1:0] s1_data_q, s1_data_d;
  logic                out_valid_q, out_valid_d;
  logic [IDX_W-1:0]    out_idx_q, out_idx_d;
  logic                out_multi_q, out_multi_d;
  logic                out_zero_q, out_zero_d;
  logic [CNT_W-1:0]    multi_cnt_q, multi_cnt_d;
  logic [CNT_W-1:0]    zero_cnt_q, zero_cnt_d;

  logic                s2_ready;
  logic                s1_adv;
  logic                out_xfer;

  logic [IDX_W-1:0]    enc_or;
  logic [IDX_W-1:0]    enc_lo;
  logic [IDX_W-1:0]    enc_idx;
  logic                enc_any;
  logic                enc_multi;

  // Handshake: a stage can take a word when empty or when its contents leave this cycle
  assign s2_ready = !out_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_ready;
  assign in_ready = !s1_valid_q || s1_adv;
  assign out_xfer = out_valid_q && out_ready;

  // Encoder over the S1 word. This computes the OR-encode, the lowest-set-bit index
  // and the multi-hot flag in one scan.
  always_comb begin
    enc_or    = '0;
    enc_lo    = '0;
    enc_any   = 1'b0;
    enc_multi = 1'b0;
    for (int unsigned i = 0; i < NUM_BINS; i++) begin
      if (s1_data_q[i]) begin
        enc_or = enc_or | IDX_W'(i);
        if (enc_any) begin
          enc_multi = 1'b1;
        end else begin
          enc_lo = IDX_W'(i);
        end
        enc_any = 1'b1;
      end
    end
  end

  assign enc_idx = (PRIO_MODE == 1) ? enc_lo : enc_or;

  // Next-state for both pipeline stages. Data is loaded only on a real advance,
  // so the outputs hold while stalled.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_multi_d = out_multi_q;
    out_zero_d  = out_zero_q;

    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_onehot;
      end
    end

    if (s2_ready) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_idx_d   = enc_idx;
        out_multi_d = enc_multi;
        out_zero_d  = !enc_any;
      end
    end
  end

  // Saturating error counters. They count on an output transfer, and clear wins.
  always_comb begin
    multi_cnt_d = multi_cnt_q;
    zero_cnt_d  = zero_cnt_q;
    if (cnt_clear) begin
      multi_cnt_d = '0;
      zero_cnt_d  = '0;
    end else begin
      if (out_xfer && out_multi_q && (multi_cnt_q != {CNT_W{1'b1}})) begin
        multi_cnt_d = multi_cnt_q + CNT_W'(1);
      end
      if (out_xfer && out_zero_q && (zero_cnt_q != {CNT_W{1'b1}})) begin
        zero_cnt_d = zero_cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_multi_q <= 1'b0;
      out_zero_q  <= 1'b0;
      multi_cnt_q <= '0;
      zero_cnt_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_multi_q <= out_multi_d;
      out_zero_q  <= out_zero_d;
      multi_cnt_q <= multi_cnt_d;
      zero_cnt_q  <= zero_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_multi = out_multi_q;
  assign out_zero  = out_zero_q;
  assign multi_cnt = multi_cnt_q;
  assign zero_cnt  = zero_cnt_q;

endmodule

// File: tb/tb_onehot_bin_encoder_pipe.sv
// tb_onehot_bin_encoder_pipe
//   Four encoder instances run in lockstep from one stimulus stream:
//   16 bins in mode 0 and mode 1, and 3 bins in mode 0 and mode 1.
//   Each instance has its own scoreboard queue and counter model.
module tb_onehot_bin_encoder_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_onehot = '0;
  logic        out_ready = 1'b1;
  logic        cnt_clear = 1'b0;
  logic        final_chk = 1'b0;
  logic [3:0]  rdy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference encoding from the bin rules. The result packs idx | multi<<8 | zero<<9.
  function automatic int ref_enc(input logic [15:0] v, input int nb, input int md);
    int idx = 0;
    int pc  = 0;
    int lo  = -1;
    for (int i = 0; i < nb; i++) begin
      if (v[i]) begin
        pc++;
        idx = idx | i;
        if (lo < 0) lo = i;
      end
    end
    if (md == 1) idx = (lo < 0) ? 0 : lo;
    return idx + ((pc >= 2) ? 256 : 0) + ((pc == 0) ? 512 : 0);
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned NB = (g < 2) ? 16 : 3;
    localparam int unsigned MD = g % 2;
    localparam int unsigned CW = (g % 2 == 0) ? 4 : 16;
    localparam int unsigned IW = $clog2(NB);

    logic          ir, ov, om, oz;
    logic [IW-1:0] oi;
    logic [CW-1:0] mc, zc;

    onehot_bin_encoder_pipe #(
      .NUM_BINS (NB),
      .PRIO_MODE(MD),
      .CNT_W    (CW)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (ir),
      .in_onehot(in_onehot[NB-1:0]),
      .out_valid(ov),
      .out_ready(out_ready),
      .out_idx  (oi),
      .out_multi(om),
      .out_zero (oz),
      .cnt_clear(cnt_clear),
      .multi_cnt(mc),
      .zero_cnt (zc)
    );

    assign rdy[g] = ir;

    int q[$];
    int exp_m = 0;
    int exp_z = 0;
    bit rst_prev = 1'b1;
    bit hold = 1'b0;
    int held = 0;

    // Monitor/scoreboard. It samples on the falling edge, halfway between active edges.
    always @(negedge clk) begin
      int e;
      int act;
      int cmax;
      cmax = (1 << CW) - 1;
      act  = int'(oi) + (om ? 256 : 0) + (oz ? 512 : 0);
      if (rst_prev) begin
        chk(!ov && act == 0 && mc == '0 && zc == '0, $sformatf("d%0d_reset_outputs", g),
            int'(ov) * 1024 + act, 0);
        chk(ir == 1'b1, $sformatf("d%0d_reset_in_ready", g), int'(ir), 1);
      end else begin
        chk(int'(mc) == exp_m, $sformatf("d%0d_multi_cnt", g), int'(mc), exp_m);
        chk(int'(zc) == exp_z, $sformatf("d%0d_zero_cnt", g), int'(zc), exp_z);
      end
      if (hold) begin
        chk(ov && act == held, $sformatf("d%0d_stall_stable", g),
            int'(ov) * 1024 + act, 1024 + held);
      end
      if (final_chk) begin
        chk(q.size() == 0, $sformatf("d%0d_drained", g), q.size(), 0);
      end
      if (rst) begin
        q.delete();
        exp_m = 0;
        exp_z = 0;
        hold  = 1'b0;
      end else begin
        if (ov && out_ready) begin
          if (q.size() == 0) begin
            chk(1'b0, $sformatf("d%0d_unexpected_output", g), act, -1);
          end else begin
            e = q.pop_front();
            chk(act == e, $sformatf("d%0d_word", g), act, e);
            if (!cnt_clear) begin
              if (e >= 512 && exp_z < cmax) exp_z++;
              if (e >= 256 && e < 512 && exp_m < cmax) exp_m++;
            end
          end
        end
        if (cnt_clear) begin
          exp_m = 0;
          exp_z = 0;
        end
        if (in_valid && ir) q.push_back(ref_enc(in_onehot, int'(NB), int'(MD)));
        hold = ov && !out_ready;
        held = act;
      end
      rst_prev = rst;
    end
  end

  // Apply inputs just after the active edge, and report acceptance at the falling edge.
  task automatic drive(input bit v, input logic [15:0] d, input bit ordy, input bit clr,
                       output bit acc);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_onehot = d;
    out_ready = ordy;
    cnt_clear = clr;
    @(negedge clk);
    acc = v && (&rdy);
  endtask

  task automatic send(input logic [15:0] d, input bit ordy);
    bit acc = 1'b0;
    int n = 0;
    do begin
      drive(1'b1, d, ordy, 1'b0, acc);
      n++;
    end while (!acc && n < 100);
    if (!acc) chk(1'b0, "send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 1'b1, 1'b0, acc);
  endtask

  function automatic logic [15:0] gen_word();
    logic [15:0] w;
    case ($urandom_range(0, 3))
      0:       w = 16'h1 << $urandom_range(0, 15);
      1:       w = 16'h0;
      default: w = 16'($urandom);
    endcase
    return w;
  endfunction

  initial begin
    bit          acc;
    bit          have;
    logic [15:0] d;
    int          sent;
    int          nacc;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Walking one-hot at full throughput
    for (int i = 0; i < 16; i++) send(16'h1 << i, 1'b1);
    idle(4);

    // Zero-hot, multi-hot and 3-bin corner words
    send(16'h0000, 1'b1);
    send(16'h0028, 1'b1);
    send(16'h0004, 1'b1);
    send(16'h0003, 1'b1);
    idle(4);

    // Saturation, then a clear that coincides with a zero-hot output transfer
    for (int i = 0; i < 20; i++) send(16'h0000, 1'b1);
    drive(1'b1, 16'h0000, 1'b1, 1'b1, acc);
    idle(4);

    // Random traffic with random backpressure and occasional clears
    have = 1'b0;
    sent = 0;
    d    = '0;
    for (int c = 0; c < 80000 && sent < 10000; c++) begin
      if (!have) begin
        d    = gen_word();
        have = 1'b1;
      end
      drive(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 63) == 0), acc);
      if (acc) begin
        have = 1'b0;
        sent++;
      end
    end
    chk(sent == 10000, "random_words_sent", sent, 10000);
    idle(6);

    // Fill both stages under backpressure, then reset mid-transfer
    nacc = 0;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 16'h0100, 1'b0, 1'b0, acc);
      if (acc) nacc++;
      else break;
    end
    chk(nacc == 2, "fill_accepted", nacc, 2);
    chk(rdy == 4'h0, "fill_in_ready_low", int'(rdy), 0);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    send(16'h0200, 1'b1);
    idle(6);

    @(posedge clk);
    #1 final_chk = 1'b1;
    @(negedge clk);
    #1 final_chk = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
